sram_port_ctrl: RTL and testbench
=================================

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 Parameter DEPTH, default 2048: number of words in the attached 1R1W SRAM array.
REQ-002 Parameter ADDR_W, default 11: address width, equal to log2(DEPTH).
REQ-003 Parameter DATA_W, default 12: data width.
REQ-004 clock  in  1  single clock; the controller and the attached SRAM's R0_clk and W0_clk all use it.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  controller accepts a request this cycle.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  request address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 resp_valid  out  1  read response present.
REQ-012 resp_ready  in  1  consumer takes the response.
REQ-013 resp_data  out  DATA_W  read data.
REQ-014 busy  out  1  initialisation sweep in progress.
REQ-015 sram_R0_en, sram_R0_addr  out  1, ADDR_W  drive the SRAM read port.
REQ-016 sram_R0_data  in  DATA_W  SRAM read data, valid the cycle after sram_R0_en.
REQ-017 sram_W0_en, sram_W0_addr, sram_W0_data  out  1, ADDR_W, DATA_W  drive the SRAM write port.

Function
REQ-018 A request is accepted when req_valid and req_ready are both 1 in the same cycle.
REQ-019 req_ready = (state==RUN) && (fifo_count + rd_inflight < 2); it is independent of req_valid and req_write.
REQ-020 Accepted write at cycle T: sram_W0_en=1 with addr/data in cycle T; no response is produced.
REQ-021 Accepted read at cycle T: sram_R0_en=1 with addr in cycle T; rd_inflight=1 in cycle T+1.
REQ-022 In cycle T+1 the controller captures sram_R0_data into a 2-entry response FIFO, which is written at the clock edge ending T+1.
REQ-023 Read latency: resp_valid no earlier than T+2, and exactly T+2 when the FIFO is empty.
REQ-024 Responses are returned in request order.
REQ-025 A FIFO entry pops when resp_valid && resp_ready.
REQ-026 resp_data shows the FIFO head and holds stable while resp_valid && !resp_ready.
REQ-027 Push and pop may occur in the same cycle; fifo_count is then unchanged.
REQ-028 Write at T, then read of the same address at T+1: the read returns the new data.
REQ-029 Read at T, then write of the same address at T+1: the read returns the old data.
REQ-030 With resp_ready held 0, at most two reads are outstanding; req_ready stays 0 until a pop.
REQ-031 sram_R0_en and sram_W0_en are 0 in every cycle without an accepted request, except during the INIT sweep.
REQ-032 State machine states:
- INIT: clearing sweep, busy=1, req_ready=0.
- RUN: normal operation, busy=0.
REQ-033 Transitions: INIT -> RUN after the write to address DEPTH-1; RUN is terminal until reset.

Reset
REQ-034 While reset_n=0 at a clock edge, the following are cleared: fifo_count=0, rd_inflight=0, init counter=0, FIFO contents zeroed.
REQ-035 After that edge the outputs are resp_valid=0, resp_data=0, sram_R0_en=0 and sram_W0_en=0.
REQ-036 The state after reset is INIT if SRAM_PORT_CTRL_INIT_EN is defined, else RUN.
REQ-037 A reset asserted mid-sweep restarts the sweep from address 0.
REQ-038 A reset asserted while a read is in flight discards that read; no response is produced for it.

Configuration
REQ-039 Macro SRAM_PORT_CTRL_INIT_EN defined:
- INIT writes 0 to addresses 0..DEPTH-1, one per cycle, using sram_W0_*.
- The sweep lasts DEPTH cycles, and busy=1 throughout.
- The init counter is ADDR_W+1 bits wide and is not allowed to wrap.
REQ-040 Macro SRAM_PORT_CTRL_INIT_EN undefined:
- No init counter is built.
- busy is tied to 0.
- req_ready may be 1 in the first cycle after reset deasserts.

Structure
REQ-041 Package sram_port_ctrl_pkg holds DEPTH, ADDR_W and DATA_W defaults and the state enum {INIT, RUN}.
REQ-042 The 2-entry response FIFO is sub-module sram_port_ctrl_resp_fifo:
- Ports: push, push_data, pop, head_data, count.
- It is combinationally safe for simultaneous push and pop.

Verification
REQ-043 With INIT_EN, release reset -> busy=1 for exactly 2048 cycles, sram_W0_addr steps 0..2047 with data 0, then req_ready=1.
REQ-044 Write addr 0x005 data 0xABC, next cycle read 0x005, resp_ready=1 -> resp_valid two cycles after the read with resp_data=0xABC.
REQ-045 Same address holding 0x111: read 0x7FF at T, write 0x7FF data 0x222 at T+1 -> response 0x111; a later read -> 0x222.
REQ-046 resp_ready=0, three back-to-back reads -> only two accepted, req_ready=0, resp_data stable. Then resp_ready=1 -> both responses in order, then the third read is accepted.
REQ-047 Assert reset_n=0 at sweep address 1000 -> sweep restarts at 0 and busy lasts a full 2048 cycles.
REQ-048 Without INIT_EN, release reset -> busy=0 and req_ready=1 in the first cycle; back-to-back reads with resp_ready=1 sustain one response per cycle.

Source files
------------

// File: rtl/sram_port_ctrl_pkg.sv
// Shared defaults and state encoding for the SRAM port controller.
package sram_port_ctrl_pkg;
  localparam int DEPTH_DEF  = 2048;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 12;

  typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the controller (slave).
interface sram_port_ctrl_if
  import sram_port_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/sram_port_ctrl_resp_fifo.sv
// Two-entry read-response FIFO; push and pop in the same cycle leave count unchanged.
module sram_port_ctrl_resp_fifo #(
  parameter int DATA_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign do_pop    = pop && (count != 2'd0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/sram_port_ctrl.sv
// Single-port request front end for a 1R1W SRAM with in-order read responses.
// Define SRAM_PORT_CTRL_INIT_EN to clear the array with a zero-write sweep after reset.
module sram_port_ctrl
  import sram_port_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  sram_port_ctrl_if.slave   bus,
  output logic              busy,
  output logic              sram_R0_en,
  output logic [ADDR_W-1:0] sram_R0_addr,
  input  logic [DATA_W-1:0] sram_R0_data,
  output logic              sram_W0_en,
  output logic [ADDR_W-1:0] sram_W0_addr,
  output logic [DATA_W-1:0] sram_W0_data
);
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR_W");
  end

  state_e            state;
  logic              run, acc, rd_acc, wr_acc, pop;
  logic              rd_inflight;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] head_data;

  // Outputs are forced quiet while reset is held so the SRAM sees no traffic.
  assign run           = (state == RUN) && reset_n;
  assign bus.req_ready = run && ((fifo_count + 2'(rd_inflight)) < 2'd2);
  assign acc           = bus.req_valid && bus.req_ready;
  assign rd_acc        = acc && !bus.req_write;
  assign wr_acc        = acc && bus.req_write;
  assign bus.resp_valid = (fifo_count != 2'd0);
  assign bus.resp_data  = head_data;
  assign pop           = bus.resp_valid && bus.resp_ready;

  assign sram_R0_en   = rd_acc;
  assign sram_R0_addr = bus.req_addr;

  always_ff @(posedge clock) begin
    if (!reset_n) rd_inflight <= 1'b0;
    else          rd_inflight <= rd_acc;
  end

  sram_port_ctrl_resp_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_inflight),
    .push_data (sram_R0_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

`ifdef SRAM_PORT_CTRL_INIT_EN
  logic [ADDR_W:0] init_cnt;
  logic            sweep;

  assign sweep = (state == INIT) && reset_n;
  assign busy  = (state == INIT);

  // Counter parks at DEPTH once RUN is reached; it never wraps back into the array.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == (ADDR_W+1)'(DEPTH - 1)) state <= RUN;
    end
  end

  assign sram_W0_en   = sweep || wr_acc;
  assign sram_W0_addr = sweep ? init_cnt[ADDR_W-1:0] : bus.req_addr;
  assign sram_W0_data = sweep ? '0 : bus.req_wdata;
`else
  assign state        = RUN;
  assign busy         = 1'b0;
  assign sram_W0_en   = wr_acc;
  assign sram_W0_addr = bus.req_addr;
  assign sram_W0_data = bus.req_wdata;
`endif
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Random and directed checks of sram_port_ctrl against a queue-based behavioural model.
module tb_sram_port_ctrl;
  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 12;
`ifdef SRAM_PORT_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              busy;
  logic              sram_R0_en, sram_W0_en;
  logic [ADDR_W-1:0] sram_R0_addr, sram_W0_addr;
  logic [DATA_W-1:0] sram_R0_data, sram_W0_data;

  sram_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_port_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .busy         (busy),
    .sram_R0_en   (sram_R0_en),
    .sram_R0_addr (sram_R0_addr),
    .sram_R0_data (sram_R0_data),
    .sram_W0_en   (sram_W0_en),
    .sram_W0_addr (sram_W0_addr),
    .sram_W0_data (sram_W0_data)
  );

  always #5 clock = ~clock;

  // Attached SRAM: registered read, write-after-read within one edge.
  logic [DATA_W-1:0] sram [DEPTH];
  always @(posedge clock) begin
    if (sram_R0_en) sram_R0_data <= sram[sram_R0_addr];
    if (sram_W0_en) sram[sram_W0_addr] <= sram_W0_data;
  end

  int n_chk = 0, n_pass = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // Behavioural model: memory image, pending responses, one read in the SRAM pipe.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] rq[$];
  bit                inf_v;
  logic [DATA_W-1:0] inf_d;
  int                init_left;
  bit                rst_edge;
  bit                e_busy, e_ready, e_rd, e_wr;
  int                cyc = 0;
  logic [DATA_W-1:0] got[$];
  int                got_cyc[$];

  always @(negedge clock) begin
    if (!reset_n) begin
      if (rst_edge) begin
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_r0_en", sram_R0_en, 0);
        chk("rst_w0_en", sram_W0_en, 0);
      end
    end else begin
      e_busy  = init_left > 0;
      e_ready = !e_busy && (rq.size() + int'(inf_v) < 2);
      e_rd    = bus.req_valid && e_ready && !bus.req_write;
      e_wr    = bus.req_valid && e_ready && bus.req_write;
      chk("busy", busy, e_busy);
      chk("req_ready", bus.req_ready, e_ready);
      chk("resp_valid", bus.resp_valid, rq.size() != 0);
      if (rq.size() != 0) chk("resp_data", bus.resp_data, rq[0]);
      chk("r0_en", sram_R0_en, e_rd);
      if (e_rd) chk("r0_addr", sram_R0_addr, bus.req_addr);
      chk("w0_en", sram_W0_en, e_wr || e_busy);
      if (e_busy) begin
        chk("sweep_addr", sram_W0_addr, DEPTH - init_left);
        chk("sweep_data", sram_W0_data, 0);
      end else if (e_wr) begin
        chk("w0_addr", sram_W0_addr, bus.req_addr);
        chk("w0_data", sram_W0_data, bus.req_wdata);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        got.push_back(bus.resp_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      rq.delete();
      inf_v     = 1'b0;
      init_left = INIT_EN ? DEPTH : 0;
      rst_edge  = 1'b1;
    end else begin
      rst_edge = 1'b0;
      if (rq.size() != 0 && bus.resp_ready) void'(rq.pop_front());
      if (inf_v) rq.push_back(inf_d);
      inf_v = e_rd;
      if (e_rd) inf_d = ref_mem[bus.req_addr];
      if (e_wr) ref_mem[bus.req_addr] = bus.req_wdata;
      if (init_left > 0) begin
        ref_mem[DEPTH - init_left] = '0;
        init_left--;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    step(n);
    reset_n = 1'b1;
  endtask

  task automatic issue(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       output int when);
    bit ok = 1'b0;
    int n = 0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    while (!ok && n < 50) begin
      @(negedge clock); ok = bus.req_ready;
      @(posedge clock); #1; n++;
    end
    if (!ok) chk("issue_timeout", 0, 1);
    when = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic measure_busy(output int n, output logic [ADDR_W-1:0] a0);
    n = 0; a0 = '1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (i == 0) a0 = sram_W0_addr;
      if (!busy) break;
      n++;
    end
    step(1);
  endtask

  initial begin
    int w1, w2, nb, k;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] v;
    bit ok;
    for (int i = 0; i < DEPTH; i++) begin
      v = DATA_W'($urandom);
      sram[i] = v; ref_mem[i] = v;
    end
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;

`ifdef SRAM_PORT_CTRL_INIT_EN
    measure_busy(nb, a0);
    chk("init_busy_len", nb, 2048);
    chk("init_first_addr", a0, 0);
    chk("ready_after_init", bus.req_ready, 1);
    // Restart the sweep partway through.
    do_reset(2);
    k = 0;
    do begin @(negedge clock); k++; end while (sram_W0_addr != 11'd1000 && k < 3000);
    chk("reach_addr_1000", sram_W0_addr, 1000);
    @(posedge clock); #1;
    do_reset(2);
    measure_busy(nb, a0);
    chk("restart_busy_len", nb, 2048);
    chk("restart_first_addr", a0, 0);
`else
    @(negedge clock);
    chk("first_busy", busy, 0);
    chk("first_ready", bus.req_ready, 1);
    step(1);
`endif

    // Write then read the same address on the next cycle.
    issue(1, 11'h005, 12'hABC, w1);
    issue(0, 11'h005, 12'h000, w2);
    @(negedge clock); chk("raw_t1_valid", bus.resp_valid, 0);
    @(negedge clock); chk("raw_t2_valid", bus.resp_valid, 1);
    chk("raw_t2_data", bus.resp_data, 12'hABC);
    step(1);

    // Read then write the same address on the next cycle.
    issue(1, 11'h7FF, 12'h111, w1); step(2); got.delete();
    issue(0, 11'h7FF, 12'h000, w1);
    issue(1, 11'h7FF, 12'h222, w2);
    step(3);
    issue(0, 11'h7FF, 12'h000, w1);
    step(4);
    chk("war_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("war_old", got[0], 12'h111);
      chk("war_new", got[1], 12'h222);
    end

    // Backpressure: two reads outstanding, third held off.
    issue(1, 11'h010, 12'h333, w1); step(1);
    bus.resp_ready = 1'b0; got.delete();
    issue(0, 11'h005, 12'h000, w1);
    issue(0, 11'h7FF, 12'h000, w2);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 11'h010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_valid", bus.resp_valid, 1);
      chk("bp_data", bus.resp_data, 12'hABC);
      @(posedge clock); #1;
    end
    bus.resp_ready = 1'b1;
    ok = 1'b0; k = 0;
    while (!ok && k < 10) begin
      @(negedge clock); ok = bus.req_ready;
      @(posedge clock); #1; k++;
    end
    chk("bp_third_accepted", ok, 1);
    bus.req_valid = 1'b0;
    step(4);
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_r0", got[0], 12'hABC);
      chk("bp_r1", got[1], 12'h222);
      chk("bp_r2", got[2], 12'h333);
    end

    // Back-to-back reads return on consecutive cycles.
    got.delete(); got_cyc.delete();
    issue(0, 11'h005, 12'h000, w1);
    issue(0, 11'h010, 12'h000, w2);
    step(4);
    chk("b2b_accept_gap", w2 - w1, 1);
    chk("b2b_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_first_lat", got_cyc[0], w1 + 1);
      chk("b2b_resp_gap", got_cyc[1] - got_cyc[0], 1);
      chk("b2b_d0", got[0], 12'hABC);
      chk("b2b_d1", got[1], 12'h333);
    end

    // Random traffic with a small hot address set, plus a reset mid-stream.
    for (int i = 0; i < 700; i++) begin
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.req_write  = 1'($urandom_range(0, 1));
      bus.req_addr   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      bus.req_wdata  = DATA_W'($urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      if (i == 499) begin bus.req_valid = 1'b1; bus.req_write = 1'b0; end
      if (i == 500) do_reset(2);
      else step(1);
    end
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    step(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
